clip_player: RTL and testbench
==============================

CLIP_PLAYER -- requirements
Module: clip_player

Interface
REQ-001 Parameter SAMPLE_DIV, default 2000, clock cycles per audio sample (50 kHz at 100 MHz); legal range 4..65535.
REQ-002 clock  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 play  input  1  start request, sampled every cycle; acted on only in IDLE.
REQ-005 stop  input  1  abort request; wins over play in the same cycle.
REQ-006 clipPlayNum  input  1  clip select: 0 = memory 0, 1 = memory 1; latched on play acceptance.
REQ-007 clipLen0, clipLen1  input  18 each  sample count stored in memory 0 / 1 (0..131072); latched on play acceptance.
REQ-008 ena0, ena1  output  1 each  BRAM enables; only the selected memory's enable may assert.
REQ-009 addra  output  17  BRAM read address, shared by both memories.
REQ-010 douta0, douta1  input  16 each  BRAM read data, signed two's complement, valid 2 cycles after the enable cycle.
REQ-011 audioOut  output  1  PWM audio output.
REQ-012 playing  output  1  high while a clip is being played.
REQ-013 done  output  1  one-cycle pulse on clip completion or abort.

Function
REQ-014 FSM states: IDLE, FETCH, WAIT, LOAD, HOLD, FINISH.
REQ-015 IDLE: play=1 and stop=0 -> latch clip select, length = selected clipLen, addr = 0; go to FINISH if length = 0, else to FETCH.
REQ-016 FETCH (1 cycle): selected enable = 1, addra = addr; go to WAIT.
REQ-017 WAIT (1 cycle): all enables 0; go to LOAD.
REQ-018 LOAD (1 cycle): capture selected douta into the sample register; go to HOLD with divider = SAMPLE_DIV-4.
REQ-019 HOLD: decrement divider; at divider = 0 go to FINISH if addr = length-1, else addr = addr+1 and go to FETCH.
REQ-020 Each sample therefore occupies exactly SAMPLE_DIV cycles, FETCH to next FETCH.
REQ-021 FINISH (1 cycle): done = 1; go to IDLE.
REQ-022 playing = 1 in FETCH, WAIT, LOAD and HOLD; 0 in IDLE and FINISH.
REQ-023 addr counts 0..length-1 and does not wrap; length 131072 ends at 17'h1FFFF.
REQ-024 Duty: 8-bit duty = {~sample[15], sample[14:8]} (offset binary), updated on the LOAD edge, usable from the following cycle.
REQ-025 PWM counter: 8 bits, free-running from 0 after reset, wraps 255 -> 0.
REQ-026 audioOut = playing AND (pwm counter < duty), registered; therefore duty 0 gives a constant 0 output.
REQ-027 stop=1 in FETCH, WAIT, LOAD or HOLD -> next state FINISH, no further fetches; in IDLE or FINISH, stop is ignored.
REQ-028 play while not IDLE is ignored; clipPlayNum and clipLen changes mid-clip have no effect.
REQ-029 Length 0: FINISH on the cycle after acceptance; no enable asserted, and playing stays 0.

Reset
REQ-030 reset=1 -> next edge: state IDLE, addr 0, divider 0, sample 0, duty 0, pwm counter 0, ena0=ena1=0, addra=0, audioOut=0, playing=0, done=0.
REQ-031 Reset mid-clip aborts without a done pulse; reset has priority over play and stop.

Verification (SAMPLE_DIV=8; BRAM model with 2-cycle read latency)
REQ-032 clip0 length 3, data 16'h8000, 16'h0000, 16'h7FFF; play pulse at cycle t:
- ena0 high at t+1, t+9 and t+17, with addra 0, 1 and 2;
- duty 0x00, 0x80 and 0xFF;
- done at t+25; playing high from t+1 to t+24.
REQ-033 clipLen1=0, clipPlayNum=1, play pulse:
- done exactly 1 cycle later;
- ena0 and ena1 never assert; playing stays 0.
REQ-034 clip1 length 5, stop asserted in the 2nd sample's HOLD:
- FINISH on the next cycle with one done pulse;
- ena1 asserts exactly twice; ena0 never asserts.
REQ-035 Duty 0x40 held for 512 cycles: audioOut high exactly 128 cycles; duty 0x00 gives 0 high cycles.
REQ-036 reset during the WAIT of sample 1:
- all outputs at their reset values on the next edge, with no done pulse;
- a new play afterwards restarts from addra 0.
REQ-037 play and stop asserted together in IDLE: ignored, no fetch, and playing stays 0.

Source files
------------

// File: rtl/clip_player_if.sv
// Control, BRAM and audio signals between a clip_player and its host/memories.
// The master side owns play/stop/clip selection and the BRAM read data.
interface clip_player_if;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned LEN_W  = 18;
    localparam int unsigned DATA_W = 16;

    logic              play;
    logic              stop;
    logic              clipPlayNum;
    logic [LEN_W-1:0]  clipLen0;
    logic [LEN_W-1:0]  clipLen1;
    logic              ena0;
    logic              ena1;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] douta0;
    logic [DATA_W-1:0] douta1;
    logic              audioOut;
    logic              playing;
    logic              done;

    modport master (
        output play, stop, clipPlayNum, clipLen0, clipLen1, douta0, douta1,
        input  ena0, ena1, addra, audioOut, playing, done
    );

    modport slave (
        input  play, stop, clipPlayNum, clipLen0, clipLen1, douta0, douta1,
        output ena0, ena1, addra, audioOut, playing, done
    );
endinterface

// File: rtl/clip_player.sv
// Streams a signed 16-bit clip from one of two BRAMs, one sample per SAMPLE_DIV
// cycles, and renders each sample's top byte as an 8-bit PWM duty on audioOut.
module clip_player #(
    parameter int unsigned SAMPLE_DIV = 2000
) (
    input  logic          clock,
    input  logic          reset,
    clip_player_if.slave  bus
);
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned LEN_W  = 18;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned PWM_W  = 8;

    // FETCH, WAIT and LOAD take three of the SAMPLE_DIV cycles; HOLD covers the rest.
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SAMPLE_DIV - 4);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        LOAD,
        HOLD,
        FINISH
    } state_t;

    state_t              state;
    state_t              state_n;
    logic                sel;
    logic                sel_n;
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    len_n;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   addr_n;
    logic [DIV_W-1:0]    div;
    logic [DIV_W-1:0]    div_n;
    logic [DATA_W-1:0]   sample;
    logic [DATA_W-1:0]   sample_n;
    logic [PWM_W-1:0]    duty;
    logic [PWM_W-1:0]    duty_n;
    logic [PWM_W-1:0]    pwm;

    logic                last;
    logic                active_n;
    logic                ena0_q;
    logic                ena1_q;
    logic                playing_q;
    logic                done_q;
    logic                audio_q;

    // Only the top byte of a sample reaches the PWM.
    logic                unused_sample_lsb;
    assign unused_sample_lsb = ^sample[7:0];

    // addr is 17 bits so a 131072-sample clip ends exactly at 17'h1FFFF.
    assign last = ({1'b0, addr} == (len - LEN_W'(1)));

    assign active_n = (state_n == FETCH) || (state_n == WAIT) ||
                      (state_n == LOAD)  || (state_n == HOLD);

    // Next-state and datapath update
    always_comb begin
        state_n  = state;
        sel_n    = sel;
        len_n    = len;
        addr_n   = addr;
        div_n    = div;
        sample_n = sample;
        duty_n   = duty;

        case (state)
            IDLE: begin
                if (bus.play && !bus.stop) begin
                    sel_n   = bus.clipPlayNum;
                    len_n   = bus.clipPlayNum ? bus.clipLen1 : bus.clipLen0;
                    addr_n  = '0;
                    state_n = (len_n == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                state_n = bus.stop ? FINISH : WAIT;
            end
            WAIT: begin
                state_n = bus.stop ? FINISH : LOAD;
            end
            LOAD: begin
                sample_n = sel ? bus.douta1 : bus.douta0;
                // Offset binary: most negative sample -> duty 0, most positive -> 0xFF.
                duty_n   = {~sample_n[15], sample_n[14:8]};
                div_n    = DIV_RELOAD;
                state_n  = bus.stop ? FINISH : HOLD;
            end
            HOLD: begin
                if (bus.stop) begin
                    state_n = FINISH;
                end else if (div == '0) begin
                    if (last) begin
                        state_n = FINISH;
                    end else begin
                        addr_n  = addr + ADDR_W'(1);
                        state_n = FETCH;
                    end
                end else begin
                    div_n = div - DIV_W'(1);
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs follow the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= 1'b0;
            len       <= '0;
            addr      <= '0;
            div       <= '0;
            sample    <= '0;
            duty      <= '0;
            pwm       <= '0;
            ena0_q    <= 1'b0;
            ena1_q    <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
            audio_q   <= 1'b0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            len       <= len_n;
            addr      <= addr_n;
            div       <= div_n;
            sample    <= sample_n;
            duty      <= duty_n;
            pwm       <= pwm + PWM_W'(1);
            ena0_q    <= (state_n == FETCH) && !sel_n;
            ena1_q    <= (state_n == FETCH) &&  sel_n;
            playing_q <= active_n;
            done_q    <= (state_n == FINISH);
            audio_q   <= playing_q && (pwm < duty);
        end
    end

    assign bus.ena0     = ena0_q;
    assign bus.ena1     = ena1_q;
    assign bus.addra    = addr;
    assign bus.playing  = playing_q;
    assign bus.done     = done_q;
    assign bus.audioOut = audio_q;

endmodule

// File: tb/tb_clip_player.sv
// Directed bench for clip_player with SAMPLE_DIV=8 and two 2-cycle-latency BRAM models.
module tb_clip_player;
    localparam int unsigned DIV = 8;

    logic clk = 1'b0;
    logic rst;

    clip_player_if bus ();

    clip_player #(.SAMPLE_DIV(DIV)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // BRAM models: registered read plus one output register.
    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic [15:0] p0a, p0b, p1a, p1b;

    always @(posedge clk) begin
        if (bus.ena0) p0a <= mem0[bus.addra[7:0]];
        if (bus.ena1) p1a <= mem1[bus.addra[7:0]];
        p0b <= p0a;
        p1b <= p1a;
    end

    assign bus.douta0 = p0b;
    assign bus.douta1 = p1b;

    // Event counters, sampled mid-cycle.
    int n_ena0 = 0;
    int n_ena1 = 0;
    int n_done = 0;
    int n_aud  = 0;

    always @(negedge clk) begin
        n_ena0 += int'(bus.ena0);
        n_ena1 += int'(bus.ena1);
        n_done += int'(bus.done);
        n_aud  += int'(bus.audioOut);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic play_pulse(input logic which);
        bus.clipPlayNum = which;
        bus.play = 1'b1;
        tick();
        bus.play = 1'b0;
    endtask

    task automatic stop_pulse();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ena0"},    32'(bus.ena0),     32'd0);
        check({tag, "_ena1"},    32'(bus.ena1),     32'd0);
        check({tag, "_addra"},   32'(bus.addra),    32'd0);
        check({tag, "_audio"},   32'(bus.audioOut), 32'd0);
        check({tag, "_playing"}, 32'(bus.playing),  32'd0);
        check({tag, "_done"},    32'(bus.done),     32'd0);
        check({tag, "_duty"},    32'(dut.duty),     32'd0);
    endtask

    int b_ena0, b_ena1, b_done, b_aud;

    task automatic snap();
        b_ena0 = n_ena0;
        b_ena1 = n_ena1;
        b_done = n_done;
        b_aud  = n_aud;
    endtask

    initial begin
        rst             = 1'b1;
        bus.play        = 1'b0;
        bus.stop        = 1'b0;
        bus.clipPlayNum = 1'b0;
        bus.clipLen0    = '0;
        bus.clipLen1    = '0;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 16'h0000;
            mem1[i] = 16'h0000;
        end

        // Reset values
        tick();
        tick();
        check_idle_outputs("rst");
        rst = 1'b0;
        tick();

        // Three-sample clip from memory 0
        mem0[0] = 16'h8000;
        mem0[1] = 16'h0000;
        mem0[2] = 16'h7FFF;
        bus.clipLen0 = 18'd3;
        snap();
        play_pulse(1'b0);
        for (int k = 1; k <= 27; k++) begin
            check("clip3_ena0",    32'(bus.ena0),    32'(k == 1 || k == 9 || k == 17));
            check("clip3_ena1",    32'(bus.ena1),    32'd0);
            check("clip3_playing", 32'(bus.playing), 32'(k >= 1 && k <= 24));
            check("clip3_done",    32'(bus.done),    32'(k == 25));
            if (k == 1 || k == 9 || k == 17)
                check("clip3_addra", 32'(bus.addra), 32'((k - 1) / 8));
            if (k >= 4)
                check("clip3_duty", 32'(dut.duty), (k < 12) ? 32'h00 : (k < 20) ? 32'h80 : 32'hFF);
            tick();
        end
        check("clip3_ena0_count", 32'(n_ena0 - b_ena0), 32'd3);
        check("clip3_done_count", 32'(n_done - b_done), 32'd1);

        // Zero-length clip on memory 1
        bus.clipLen1 = 18'd0;
        snap();
        play_pulse(1'b1);
        check("len0_done_t1", 32'(bus.done), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            check("len0_playing", 32'(bus.playing), 32'd0);
            tick();
        end
        check("len0_ena0_count", 32'(n_ena0 - b_ena0), 32'd0);
        check("len0_ena1_count", 32'(n_ena1 - b_ena1), 32'd0);
        check("len0_done_count", 32'(n_done - b_done), 32'd1);

        // Stop during the second sample's HOLD on memory 1
        for (int i = 0; i < 5; i++) mem1[i] = 16'(16'h1000 * i);
        bus.clipLen1 = 18'd5;
        snap();
        play_pulse(1'b1);
        for (int k = 1; k <= 12; k++) tick();
        bus.clipLen1 = 18'd0;
        stop_pulse();
        check("stop_done",    32'(bus.done),    32'd1);
        check("stop_playing", 32'(bus.playing), 32'd0);
        for (int k = 0; k < 20; k++) tick();
        check("stop_ena1_count", 32'(n_ena1 - b_ena1), 32'd2);
        check("stop_ena0_count", 32'(n_ena0 - b_ena0), 32'd0);
        check("stop_done_count", 32'(n_done - b_done), 32'd1);

        // PWM duty 0x40 over 512 cycles
        for (int i = 0; i < 100; i++) mem0[i] = 16'hC000;
        bus.clipLen0 = 18'd100;
        play_pulse(1'b0);
        for (int k = 0; k < 20; k++) tick();
        snap();
        for (int k = 0; k < 512; k++) tick();
        check("pwm40_high", 32'(n_aud - b_aud), 32'd128);
        check("pwm40_playing", 32'(bus.playing), 32'd1);
        stop_pulse();
        for (int k = 0; k < 4; k++) tick();

        // PWM duty 0x00 over 512 cycles
        for (int i = 0; i < 100; i++) mem0[i] = 16'h8000;
        play_pulse(1'b0);
        for (int k = 0; k < 20; k++) tick();
        snap();
        for (int k = 0; k < 512; k++) tick();
        check("pwm00_high", 32'(n_aud - b_aud), 32'd0);
        check("pwm00_playing", 32'(bus.playing), 32'd1);
        stop_pulse();
        for (int k = 0; k < 4; k++) tick();

        // Reset during WAIT of sample 1, then restart
        mem0[0] = 16'h7FFF;
        mem0[1] = 16'h7FFF;
        mem0[2] = 16'h7FFF;
        bus.clipLen0 = 18'd3;
        snap();
        play_pulse(1'b0);
        for (int k = 1; k < 10; k++) tick();
        check("rstmid_addra_before", 32'(bus.addra), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("rstmid");
        for (int k = 0; k < 30; k++) tick();
        check("rstmid_done_count", 32'(n_done - b_done), 32'd0);
        check("rstmid_ena0_count", 32'(n_ena0 - b_ena0), 32'd2);
        play_pulse(1'b0);
        check("restart_ena0",  32'(bus.ena0),  32'd1);
        check("restart_addra", 32'(bus.addra), 32'd0);
        for (int k = 0; k < 30; k++) tick();

        // play and stop together in IDLE
        snap();
        bus.play = 1'b1;
        bus.stop = 1'b1;
        tick();
        bus.play = 1'b0;
        bus.stop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("playstop_playing", 32'(bus.playing), 32'd0);
            tick();
        end
        check("playstop_ena0_count", 32'(n_ena0 - b_ena0), 32'd0);
        check("playstop_done_count", 32'(n_done - b_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
